alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Issue controller that sits between instruction decode and the combinational ALU (op codes AND/OR/ADD/SUB/SLT/NOR). Accepts one ALU request per handshake, translates the 2-bit ALUOp and 6-bit funct fields into the ALU's 4-bit op code, and drives operands and op code from registers for one execute cycle. Captures the ALU's Res and Zflag, computes the branch decision, and returns the result on a valid/ready response port.

## Interface
- WIDTH, default 32: operand and result width.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_aluop  input  2  encoding:
  - 00: ADD (load/store address).
  - 01: SUB (branch compare).
  - 10: R-type, decode funct.
  - 11: illegal.
- req_funct  input  6  R-type funct field; ignored unless req_aluop=10.
- req_bne  input  1  for req_aluop=01: 1 = BNE, 0 = BEQ.
- req_a, req_b  input  WIDTH  operands.
- alu_a, alu_b  output  WIDTH  operands driven to the ALU.
- alu_op  output  4  op code driven to the ALU.
- alu_res  input  WIDTH  ALU result, combinational from alu_a/alu_b/alu_op.
- alu_zero  input  1  ALU Zflag.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_res  output  WIDTH  captured result.
- rsp_zero  output  1  captured Zflag.
- rsp_taken  output  1  branch taken; meaningful only for req_aluop=01.
- rsp_illegal  output  1  request was undecodable; no ALU issue occurred.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: register req_a into alu_a, req_b into alu_b, the decoded op into alu_op, and also register req_aluop and req_bne.
  - Legal request -> EXEC. Illegal request -> RESP with rsp_res=0, rsp_zero=0, rsp_taken=0, rsp_illegal=1.
- Decode:
  - aluop 00 -> 0010; aluop 01 -> 0110.
  - aluop 10, funct 100000 -> 0010 (ADD); 100010 -> 0110 (SUB); 100100 -> 0000 (AND); 100101 -> 0001 (OR); 100111 -> 1100 (NOR); 101010 -> 0111 (SLT).
  - Any other funct, and aluop 11, is illegal. For an illegal request alu_a, alu_b and alu_op keep their previous values.
- EXEC: alu_a, alu_b and alu_op are stable for the whole cycle. At the cycle's end, capture rsp_res=alu_res, rsp_zero=alu_zero, rsp_illegal=0, and rsp_taken=(aluop==01) ? (alu_zero ^ bne) : 0. Go to RESP.
- RESP:
  - rsp_valid=1; all rsp_* outputs stay stable until rsp_valid&&rsp_ready.
  - On that handshake -> IDLE. There is no same-cycle accept of a new request.
- alu_a, alu_b and alu_op change only on an accepted legal request. Between requests they hold their values.
- Arithmetic (wrap, signedness of SLT) is owned by the ALU; this block passes values through unmodified.

## Timing
- Legal request accepted at edge T: EXEC occupies cycle T+1, and rsp_valid=1 from cycle T+2.
- Illegal request accepted at edge T: rsp_valid=1 from cycle T+1.
- Minimum spacing between accepted requests is 3 cycles (legal) or 2 cycles (illegal) with rsp_ready held high.
- req_ready and rsp_valid are decoded from registered state only; there is no combinational path from req_valid or rsp_ready to either.
- Reset, sampled at an edge with rst=1:
  - State goes to IDLE.
  - alu_a=0, alu_b=0, alu_op=0000.
  - rsp_res=0, rsp_zero=0, rsp_taken=0, rsp_illegal=0, rsp_valid=0.
  - req_ready=0 while rst=1 and 1 from the first cycle after rst drops.
- Reset during EXEC or RESP abandons the operation: no response is ever presented.
- req_valid during EXEC or RESP is not accepted (req_ready=0), and the request is not lost.

## Test plan
- ADD: aluop=10, funct=100000, A=5, B=7 -> alu_op=0010 in EXEC; rsp_res=12, rsp_zero=0, rsp_valid at T+2.
- SLT and NOR:
  - funct=101010, A=3, B=9 -> rsp_res=1.
  - funct=100111, A=B=0 -> alu_op=1100, rsp_res=0xFFFFFFFF, rsp_zero=0.
- Branch:
  - aluop=01, bne=0, A=B=0x1234 -> alu_op=0110, rsp_zero=1, rsp_taken=1.
  - Same operands with bne=1 -> rsp_taken=0.
- Illegal:
  - funct=000000 -> rsp_valid at T+1 with rsp_illegal=1, rsp_res=0, and alu_op unchanged from the prior request.
  - aluop=11 -> same response.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP while driving a new request -> rsp_* stable, req_ready=0. Raise rsp_ready -> IDLE, then the new request is accepted.
- Reset mid-op: assert rst in EXEC -> next cycle state IDLE, all outputs at reset values, no rsp_valid pulse.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//
// Issue controller between instruction decode and a combinational ALU.
// - Accepts one request per valid/ready handshake.
// - Translates ALUOp/funct into the ALU's 4-bit op code.
// - Holds the operands and op code in registers for one execute cycle.
// - Captures the ALU result and Zflag, and computes the branch decision.
// - Returns the result on a valid/ready response port.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake
//   req_aluop         00 ADD, 01 SUB (branch), 10 R-type, 11 illegal
//   req_funct         R-type funct field
//   req_bne           branch sense for aluop 01 (1 = BNE, 0 = BEQ)
//   req_a, req_b      operands
//   alu_a/alu_b/op    registered operands and op code driven to the ALU
//   alu_res/alu_zero  combinational ALU result and Zflag
//   rsp_valid/ready   response handshake
//   rsp_res/zero      captured ALU result and Zflag
//   rsp_taken         branch decision (aluop 01 only)
//   rsp_illegal       request could not be decoded; the ALU was not used
module alu_issue_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_aluop,
  input  logic [5:0]       req_funct,
  input  logic             req_bne,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_zero,
  output logic             rsp_taken,
  output logic             rsp_illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] alu_a_reg;
  logic [WIDTH-1:0] alu_b_reg;
  logic [3:0]       alu_op_reg;
  logic [1:0]       aluop_reg;
  logic             bne_reg;
  logic [WIDTH-1:0] rsp_res_reg;
  logic             rsp_zero_reg;
  logic             rsp_taken_reg;
  logic             rsp_illegal_reg;

  logic [3:0]       dec_op;
  logic             dec_legal;

  // Decode ALUOp/funct into the ALU op code. Anything unrecognised is
  // flagged illegal, and the issue registers are then left untouched.
  always_comb begin
    dec_op    = 4'b0000;
    dec_legal = 1'b1;
    case (req_aluop)
      2'b00: dec_op = 4'b0010;
      2'b01: dec_op = 4'b0110;
      2'b10: begin
        case (req_funct)
          6'b100000: dec_op = 4'b0010;
          6'b100010: dec_op = 4'b0110;
          6'b100100: dec_op = 4'b0000;
          6'b100101: dec_op = 4'b0001;
          6'b100111: dec_op = 4'b1100;
          6'b101010: dec_op = 4'b0111;
          default:   dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      alu_a_reg       <= '0;
      alu_b_reg       <= '0;
      alu_op_reg      <= 4'b0000;
      aluop_reg       <= 2'b00;
      bne_reg         <= 1'b0;
      rsp_res_reg     <= '0;
      rsp_zero_reg    <= 1'b0;
      rsp_taken_reg   <= 1'b0;
      rsp_illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            aluop_reg <= req_aluop;
            bne_reg   <= req_bne;
            if (dec_legal) begin
              alu_a_reg  <= req_a;
              alu_b_reg  <= req_b;
              alu_op_reg <= dec_op;
              state_reg  <= EXEC;
            end else begin
              // Illegal requests skip the ALU and answer directly.
              rsp_res_reg     <= '0;
              rsp_zero_reg    <= 1'b0;
              rsp_taken_reg   <= 1'b0;
              rsp_illegal_reg <= 1'b1;
              state_reg       <= RESP;
            end
          end
        end
        EXEC: begin
          rsp_res_reg     <= alu_res;
          rsp_zero_reg    <= alu_zero;
          rsp_illegal_reg <= 1'b0;
          // BEQ is taken on zero and BNE on non-zero, so XOR with the sense bit.
          rsp_taken_reg   <= (aluop_reg == 2'b01) ? (alu_zero ^ bne_reg) : 1'b0;
          state_reg       <= RESP;
        end
        RESP: begin
          if (rsp_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Handshake flags depend only on the registered state (and on reset for
  // ready), never on req_valid or rsp_ready.
  assign req_ready   = (state_reg == IDLE) && !rst;
  assign rsp_valid   = (state_reg == RESP);
  assign alu_a       = alu_a_reg;
  assign alu_b       = alu_b_reg;
  assign alu_op      = alu_op_reg;
  assign rsp_res     = rsp_res_reg;
  assign rsp_zero    = rsp_zero_reg;
  assign rsp_taken   = rsp_taken_reg;
  assign rsp_illegal = rsp_illegal_reg;

endmodule
